// File: rtl/spi_master_arbiter_pkg.sv
// spi_master_arbiter_pkg: shared defaults and FSM state encodings for the SPI master arbiter
package spi_master_arbiter_pkg;
  localparam int c_SPI_SIZE_DEF = 8;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_RX = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick, searching from ptr+1 with wrap
module rr_arbiter #(
  parameter int c_NUM_REQ = 4,
  parameter int c_IDX_W   = $clog2(c_NUM_REQ)
) (
  input  logic [c_NUM_REQ-1:0] req,
  input  logic [c_IDX_W-1:0]   ptr,
  output logic [c_NUM_REQ-1:0] grant,
  output logic [c_IDX_W-1:0]   idx
);
  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    idx = '0;
    grant = '0;
    for (int i = c_NUM_REQ; i >= 1; i--)
      if (req[(int'(ptr) + i) % c_NUM_REQ]) idx = c_IDX_W'((int'(ptr) + i) % c_NUM_REQ);
    grant[idx] = |req;
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: per-transaction round-robin sharing of one SPI byte engine among chip-select owners
module spi_master_arbiter import spi_master_arbiter_pkg::*; #(
  parameter int c_NUM_REQ        = 4,
  parameter int c_SPI_SIZE       = c_SPI_SIZE_DEF,
  parameter int c_CS_IDLE_CYCLES = 4
) (
  input  logic                            i_clock,
  input  logic                            i_rst,
  input  logic [c_NUM_REQ-1:0]            i_req,
  input  logic [c_NUM_REQ-1:0]            i_req_last,
  input  logic [c_NUM_REQ*c_SPI_SIZE-1:0] i_req_tx_data,
  output logic [c_NUM_REQ-1:0]            o_req_ack,
  output logic [c_NUM_REQ-1:0]            o_req_rx_dv,
  output logic [c_SPI_SIZE-1:0]           o_req_rx_data,
  output logic [c_NUM_REQ-1:0]            o_grant,
  output logic [c_NUM_REQ-1:0]            o_spi_cs_n,
  output logic [c_SPI_SIZE-1:0]           o_m_tx_data,
  output logic                            o_m_tx_dv,
  input  logic                            i_m_tx_ready,
  input  logic                            i_m_rx_dv,
  input  logic [c_SPI_SIZE-1:0]           i_m_rx_data
);
  localparam int c_IDX_W = $clog2(c_NUM_REQ);
  localparam int c_GAP_W = $clog2(c_CS_IDLE_CYCLES + 1);
  logic [2:0]           state;
  logic [c_IDX_W-1:0]   ptr, pick_idx;
  logic [c_NUM_REQ-1:0] pick_grant;
  logic [c_GAP_W-1:0]   gap;
  logic                 last_q;
  rr_arbiter #(.c_NUM_REQ(c_NUM_REQ), .c_IDX_W(c_IDX_W)) u_rr (
    .req(i_req), .ptr(ptr), .grant(pick_grant), .idx(pick_idx)
  );
  // ptr doubles as the current owner's index while granted.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state <= S_IDLE;
      ptr <= c_IDX_W'(c_NUM_REQ - 1);
      gap <= '0;
      last_q <= 1'b0;
      o_grant <= '0;
      o_spi_cs_n <= '1;
      o_m_tx_data <= '0;
      o_m_tx_dv <= 1'b0;
      o_req_ack <= '0;
      o_req_rx_dv <= '0;
      o_req_rx_data <= '0;
    end else begin
      o_m_tx_dv <= 1'b0;
      o_req_ack <= '0;
      o_req_rx_dv <= '0;
      case (state)
        S_IDLE: if (|i_req) begin
          o_grant <= pick_grant;
          o_spi_cs_n <= ~pick_grant;
          ptr <= pick_idx;
          state <= S_SETUP;
        end
        S_SETUP: state <= S_SEND;
        S_SEND: if (i_req[ptr] && i_m_tx_ready) begin
          o_m_tx_dv <= 1'b1;
          o_req_ack <= o_grant;
          o_m_tx_data <= i_req_tx_data[ptr*c_SPI_SIZE +: c_SPI_SIZE];
          last_q <= i_req_last[ptr];
          state <= S_WAIT_RX;
        end
        S_WAIT_RX: if (i_m_rx_dv) begin
          o_req_rx_dv <= o_grant;
          o_req_rx_data <= i_m_rx_data;
          state <= last_q ? S_GAP : S_SEND;
          gap <= '0;
          if (last_q) begin
            o_grant <= '0;
            o_spi_cs_n <= '1;
          end
        end
        S_GAP: begin
          gap <= gap + 1'b1;
          if (gap == c_GAP_W'(c_CS_IDLE_CYCLES - 1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
